seven_segment_scan: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode/cathode 7-segment bank, used for on-board

---
 rtl/seven_segment_scan.sv | 169 ++++++++++++++++
 tb/tb_seven_segment_scan.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan.sv
// Time-multiplexed 7-segment scanner: one digit lit per refresh period, hex
// decode, per-digit decimal points, optional leading-zero blanking. Values are
// staged in a pending register and committed only when the scan wraps, so a
// frame never mixes two values.
module seven_segment_scan #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1,
  parameter int LZ_BLANK    = 1,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic                    i_enable,
  output logic [6:0]              o_segments,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_anode,
  output logic [IDX_W-1:0]        o_digit_idx,
  output logic                    o_frame_start
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam logic SEG_LOW = (SEG_ACT_LOW != 0);
  localparam logic AN_LOW  = (AN_ACT_LOW != 0);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Active-high segment pattern {A,B,C,D,E,F,G} for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'h7E;
      4'h1: hex_decode = 7'h30;
      4'h2: hex_decode = 7'h6D;
      4'h3: hex_decode = 7'h79;
      4'h4: hex_decode = 7'h33;
      4'h5: hex_decode = 7'h5B;
      4'h6: hex_decode = 7'h5F;
      4'h7: hex_decode = 7'h70;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h7B;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h1F;
      4'hC: hex_decode = 7'h4E;
      4'hD: hex_decode = 7'h3D;
      4'hE: hex_decode = 7'h4F;
      default: hex_decode = 7'h47;
    endcase
  endfunction

  logic [DIV_W-1:0]      div;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      disp_value;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [VAL_W-1:0]      pend_value;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;

  logic                  tick;
  logic                  wrap;
  logic [DIV_W-1:0]      div_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic [VAL_W-1:0]      disp_value_nxt;
  logic [NUM_DIGITS-1:0] disp_dp_nxt;

  logic [3:0]            nib;
  logic                  dp_req;
  logic                  blank;
  logic [6:0]            seg_on;
  logic                  dp_on;
  logic [NUM_DIGITS-1:0] an_on;

  // Next-state of divider, digit index and displayed value.
  always_comb begin
    tick    = (div == DIV_LAST);
    wrap    = tick && (idx == IDX_LAST);
    div_nxt = tick ? '0 : div + DIV_W'(1);
    idx_nxt = idx;
    if (tick) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
    disp_value_nxt = disp_value;
    disp_dp_nxt    = disp_dp;
    if (wrap && pend_valid) begin
      disp_value_nxt = pend_value;
      disp_dp_nxt    = pend_dp;
    end
  end

  // Pick the digit about to be driven and decide whether it is a leading zero.
  always_comb begin : sel_digit
    logic zero_above;
    nib        = 4'h0;
    dp_req     = 1'b0;
    blank      = 1'b0;
    zero_above = 1'b1;
    // Walk from the most significant digit down so zero_above covers k..top.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (disp_value_nxt[4*k +: 4] == 4'h0);
      if (idx_nxt == IDX_W'(k)) begin
        nib    = disp_value_nxt[4*k +: 4];
        dp_req = disp_dp_nxt[k];
        blank  = (LZ_BLANK != 0) && (k != 0) && zero_above;
      end
    end
    seg_on = (i_enable && !blank) ? hex_decode(nib) : 7'h00;
    dp_on  = i_enable && !blank && dp_req;
    an_on  = i_enable ? (NUM_DIGITS'(1) << idx_nxt) : '0;
  end

  // Refresh divider and scan index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= div_nxt;
      idx <= idx_nxt;
    end
  end

  // Pending capture; a load on the wrap edge re-arms pending after the commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else if (i_load) begin
      pend_value <= i_value;
      pend_dp    <= i_dp;
      pend_valid <= 1'b1;
    end else if (wrap) begin
      pend_valid <= 1'b0;
    end
  end

  // Displayed value, changed only at a frame boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_value <= '0;
      disp_dp    <= '0;
    end else begin
      disp_value <= disp_value_nxt;
      disp_dp    <= disp_dp_nxt;
    end
  end

  // Registered outputs, aligned with the index update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_anode       <= {NUM_DIGITS{AN_LOW}};
      o_segments    <= {7{SEG_LOW}};
      o_dp          <= SEG_LOW;
      o_digit_idx   <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_anode       <= an_on ^ {NUM_DIGITS{AN_LOW}};
      o_segments    <= seg_on ^ {7{SEG_LOW}};
      o_dp          <= dp_on ^ SEG_LOW;
      o_digit_idx   <= idx_nxt;
      o_frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan with 4 digits and a divide-by-4 refresh.
// A behavioural model derives the expected outputs from the number of clock
// edges since reset release; directed phases add literal expectations.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic        i_load;
  logic        i_enable;
  logic [6:0]  o_segments;
  logic        o_dp;
  logic [3:0]  o_anode;
  logic [1:0]  o_digit_idx;
  logic        o_frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  seven_segment_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_value       (i_value),
    .i_dp          (i_dp),
    .i_load        (i_load),
    .i_enable      (i_enable),
    .o_segments    (o_segments),
    .o_dp          (o_dp),
    .o_anode       (o_anode),
    .o_digit_idx   (o_digit_idx),
    .o_frame_start (o_frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]  codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int          m_edges;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_disp_dp, m_pend_dp;
  bit          m_pv;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [1:0]  e_idx;
  logic        e_fs;

  always @(posedge clk) begin
    int   k;
    logic [3:0] digit;
    bit   blank;
    if (!reset_n) begin
      m_edges = 0; m_disp = 0; m_pend = 0; m_disp_dp = 0; m_pend_dp = 0; m_pv = 0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_idx = 0; e_fs = 0;
    end else begin
      m_edges++;
      // The scan wraps every 16 edges (4 digits x 4 clocks).
      e_fs = (m_edges % 16 == 0);
      if (e_fs && m_pv) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_pv = 0;
      end
      if (i_load) begin
        m_pend = i_value; m_pend_dp = i_dp; m_pv = 1;
      end
      k      = (m_edges / 4) % 4;
      e_idx  = 2'(k);
      digit  = 4'((m_disp >> (4 * k)) & 16'hF);
      blank  = (k != 0) && ((m_disp >> (4 * k)) == 0);
      e_an   = i_enable ? ~(4'(1 << k)) : 4'hF;
      e_seg  = (i_enable && !blank) ? ~codes[digit] : 7'h7F;
      e_dp   = !(i_enable && !blank && m_disp_dp[k]);
    end
    #1;
    check("model_anode", o_anode, e_an);
    check("model_segments", o_segments, e_seg);
    check("model_dp", o_dp, e_dp);
    check("model_idx", o_digit_idx, e_idx);
    check("model_frame_start", o_frame_start, e_fs);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    check({tag, "_anode"}, o_anode, an);
    check({tag, "_segments"}, o_segments, seg);
    check({tag, "_dp"}, o_dp, dp);
  endtask

  task automatic wait_frame(input string tag);
    int t = 0;
    step();
    while (o_frame_start !== 1'b1 && t < 40) begin
      step();
      t++;
    end
    check({tag, "_frame_seen"}, o_frame_start, 1'b1);
  endtask

  initial begin
    reset_n = 1'b0; i_value = 0; i_dp = 0; i_load = 0; i_enable = 1;
    repeat (3) step();
    expect_out("reset", 4'hF, 7'h7F, 1'b1);
    check("reset_idx", o_digit_idx, 2'd0);
    check("reset_fs", o_frame_start, 1'b0);

    // Release and watch digit 0 light with "0", then advance to digit 1.
    reset_n = 1'b1;
    step();
    expect_out("release", 4'hE, 7'h01, 1'b1);
    check("release_fs", o_frame_start, 1'b0);
    repeat (3) step();
    expect_out("idx1_blank", 4'hD, 7'h7F, 1'b1);
    check("idx1", o_digit_idx, 2'd1);

    // Mid-frame load of 00A3.
    step();
    i_value = 16'h00A3; i_dp = 4'b0000; i_load = 1;
    step();
    i_load = 0;
    check("a3_not_yet", o_segments, 7'h7F);
    wait_frame("a3");
    expect_out("a3_d0", 4'hE, 7'h06, 1'b1);
    check("a3_idx0", o_digit_idx, 2'd0);
    repeat (4) step();
    expect_out("a3_d1", 4'hD, 7'h08, 1'b1);
    check("a3_fs_gone", o_frame_start, 1'b0);
    repeat (4) step();
    expect_out("a3_d2", 4'hB, 7'h7F, 1'b1);
    repeat (4) step();
    expect_out("a3_d3", 4'h7, 7'h7F, 1'b1);

    // All-zero value with dp requested on a blanked digit.
    i_value = 16'h0000; i_dp = 4'b0100; i_load = 1;
    step();
    i_load = 0;
    wait_frame("zero");
    expect_out("zero_d0", 4'hE, 7'h01, 1'b1);
    repeat (8) step();
    expect_out("zero_d2", 4'hB, 7'h7F, 1'b1);

    // Load on the wrap edge while another value is pending.
    wait_frame("wrapld");
    for (int i = 1; i <= 15; i++) begin
      step();
      i_load = 0;
      if (i == 2)  begin i_value = 16'h2222; i_dp = 4'b0000; i_load = 1; end
      if (i == 15) begin i_value = 16'h1111; i_dp = 4'b0000; i_load = 1; end
    end
    step();
    i_load = 0;
    check("wrapld_fs", o_frame_start, 1'b1);
    expect_out("wrapld_2222", 4'hE, 7'h12, 1'b1);
    wait_frame("wrapld_next");
    expect_out("wrapld_1111", 4'hE, 7'h4F, 1'b1);

    // Display disabled for 20 cycles; scanning keeps going.
    i_enable = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      expect_out("dark", 4'hF, 7'h7F, 1'b1);
      if (i == 4) check("dark_idx_steps", o_digit_idx, 2'd1);
    end
    i_enable = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] mask;
      step();
      case ($urandom_range(0, 4))
        0: mask = 16'h0000;
        1: mask = 16'h000F;
        2: mask = 16'h00FF;
        3: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      i_value  = 16'($urandom) & mask;
      i_dp     = 4'($urandom);
      i_load   = ($urandom_range(0, 7) == 0);
      i_enable = ($urandom_range(0, 9) != 0);
    end
    step();
    i_load = 0; i_enable = 1;

    // Reset pulse with a load pending: the pending value must be discarded.
    wait_frame("rst");
    i_value = 16'h5555; i_dp = 4'b1111; i_load = 1;
    step();
    i_load = 0;
    repeat (3) step();
    reset_n = 0;
    #1;
    expect_out("rst_async", 4'hF, 7'h7F, 1'b1);
    check("rst_async_idx", o_digit_idx, 2'd0);
    step(); step();
    reset_n = 1;
    step();
    check("rst_release_fs", o_frame_start, 1'b0);
    expect_out("rst_release", 4'hE, 7'h01, 1'b1);
    wait_frame("rst_after");
    expect_out("rst_after_d0", 4'hE, 7'h01, 1'b1);
    repeat (4) step();
    expect_out("rst_after_d1", 4'hD, 7'h7F, 1'b1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
